p4_cpu_control: RTL



---
 rtl/p4_cpu_control.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/p4_cpu_control.sv
// p4_cpu_control: instruction register, decoder and controller FSM for the
// Simple RISC Machine. It drives every control input of the P3 datapath.
// Optional build macro: SRM_ILLEGAL_TRAP_EN adds a sticky 'illegal' output.
// When that flag is set, the controller refuses to start new instructions
// until reset.
module p4_cpu_control (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] in,
  input  logic        load,
  input  logic        s,
  output logic        w,
  output logic [15:0] datapath_in,
  output logic [2:0]  writenum,
  output logic [2:0]  readnum,
  output logic        write,
  output logic        loada,
  output logic        loadb,
  output logic        loadc,
  output logic        loads,
  output logic        asel,
  output logic        bsel,
  output logic        vsel,
  output logic [1:0]  shift,
  output logic [1:0]  ALUop
`ifdef SRM_ILLEGAL_TRAP_EN
  ,
  output logic        illegal
`endif
);

  typedef enum logic [2:0] {
    S_WAIT,
    S_DECODE,
    S_WIMM,
    S_GETA,
    S_GETB,
    S_EXEC,
    S_WREG
  } state_t;

  // One control word. It is registered as a whole so that every output
  // comes straight from a flop.
  typedef struct packed {
    logic       w;
    logic [2:0] writenum;
    logic [2:0] readnum;
    logic       write;
    logic       loada;
    logic       loadb;
    logic       loadc;
    logic       loads;
    logic       asel;
    logic       bsel;
    logic       vsel;
    logic [1:0] shift;
    logic [1:0] aluOp;
  } ctrl_t;

  state_t      state_q, state_d;
  logic [15:0] ir_q, ir_d;
  ctrl_t       ctrl_q;
  logic        trapHold;

`ifdef SRM_ILLEGAL_TRAP_EN
  logic illegal_q, illegal_d;
  assign trapHold = illegal_q;
  assign illegal  = illegal_q;
`else
  assign trapHold = 1'b0;
`endif

  // Control word each state presents. The result depends only on the
  // state and the IR, so the outputs behave as Moore outputs.
  function automatic ctrl_t decodeCtrl(input state_t st, input logic [15:0] ir);
    ctrl_t c;
    c = '0;
    case (st)
      S_WAIT: c.w = 1'b1;
      S_WIMM: begin
        c.writenum = ir[10:8];
        c.vsel     = 1'b1;
        c.write    = 1'b1;
      end
      S_GETA: begin
        c.readnum = ir[10:8];
        c.loada   = 1'b1;
      end
      S_GETB: begin
        c.readnum = ir[2:0];
        c.loadb   = 1'b1;
      end
      S_EXEC: begin
        c.shift = ir[4:3];
        if (ir[15:13] == 3'b110) begin
          c.asel  = 1'b1;
          c.aluOp = 2'b00;
        end else begin
          c.aluOp = ir[12:11];
        end
        if (ir[15:11] == 5'b10101) c.loads = 1'b1;
        else                       c.loadc = 1'b1;
      end
      S_WREG: begin
        c.writenum = ir[7:5];
        c.write    = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  // Next state and next IR. The IR is only writable while idle, and an
  // undefined opcode falls straight back to WAIT.
  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
`ifdef SRM_ILLEGAL_TRAP_EN
    illegal_d = illegal_q;
`endif
    case (state_q)
      S_WAIT: begin
        if (load) ir_d = in;
        if (s && !trapHold) state_d = S_DECODE;
      end
      S_DECODE: begin
        case (ir_q[15:11])
          5'b11010: state_d = S_WIMM;
          5'b11000: state_d = S_GETB;
          5'b10100,
          5'b10101,
          5'b10110: state_d = S_GETA;
          5'b10111: state_d = S_GETB;
          default: begin
            state_d = S_WAIT;
`ifdef SRM_ILLEGAL_TRAP_EN
            illegal_d = 1'b1;
`endif
          end
        endcase
      end
      S_WIMM: state_d = S_WAIT;
      S_GETA: state_d = S_GETB;
      S_GETB: state_d = S_EXEC;
      S_EXEC: state_d = (ir_q[15:11] == 5'b10101) ? S_WAIT : S_WREG;
      S_WREG: state_d = S_WAIT;
      default: state_d = S_WAIT;
    endcase
  end

  // State, IR and the registered control word. The control word is built
  // from the next state so it lines up with the state it describes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_WAIT;
      ir_q     <= '0;
      ctrl_q   <= '0;
      ctrl_q.w <= 1'b1;
`ifdef SRM_ILLEGAL_TRAP_EN
      illegal_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      ctrl_q  <= decodeCtrl(state_d, ir_d);
`ifdef SRM_ILLEGAL_TRAP_EN
      illegal_q <= illegal_d;
`endif
    end
  end

  assign datapath_in = {{8{ir_q[7]}}, ir_q[7:0]};
  assign w        = ctrl_q.w;
  assign writenum = ctrl_q.writenum;
  assign readnum  = ctrl_q.readnum;
  assign write    = ctrl_q.write;
  assign loada    = ctrl_q.loada;
  assign loadb    = ctrl_q.loadb;
  assign loadc    = ctrl_q.loadc;
  assign loads    = ctrl_q.loads;
  assign asel     = ctrl_q.asel;
  assign bsel     = ctrl_q.bsel;
  assign vsel     = ctrl_q.vsel;
  assign shift    = ctrl_q.shift;
  assign ALUop    = ctrl_q.aluOp;

endmodule
